pe_mac_pool: RTL and testbench

// Second-generation processing element for the conv/pool array. Owns ifmap and weight scratchpads
// of parametrised depth and runs a full multi-tap dot product (with bias) or max-pool window per job.
// A built-in FSM sequences load -> compute -> output; the array controller only issues start and

---
 rtl/pe_pkg.sv | 43 ++++
 rtl/pe_mac_pool_scratchpad.sv | 25 ++
 rtl/pe_mac_pool.sv | 189 ++++++++++++++++++
 tb/tb_pe_mac_pool.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and width-generic arithmetic helpers for the conv/pool processing element.
package pe_pkg;

    localparam int MAXW = 64;

    typedef enum logic {CONV = 1'b0, MAXPOOL = 1'b1} pe_mode_e;

    typedef logic [1:0] pe_state_e;
    localparam pe_state_e IDLE    = 2'd0;
    localparam pe_state_e LOAD    = 2'd1;
    localparam pe_state_e COMPUTE = 2'd2;
    localparam pe_state_e OUT     = 2'd3;

    // Sign-extend the low w bits of v to the full MAXW width.
    function automatic logic [MAXW-1:0] sext(input logic [MAXW-1:0] v, input int unsigned w);
        logic signed [MAXW-1:0] t;
        t = $signed(v << (MAXW - w));
        return t >>> (MAXW - w);
    endfunction

    function automatic logic [MAXW-1:0] sat_add(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                               input int unsigned w);
        logic signed [MAXW-1:0] sum;
        logic signed [MAXW-1:0] hi;
        logic [MAXW-1:0]        res;
        sum = $signed(sext(a, w)) + $signed(sext(b, w));
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        if (sum > hi)       res = hi;
        else if (sum < ~hi) res = ~hi;
        else                res = sum;
        return res;
    endfunction

    function automatic logic sat_hit(input logic [MAXW-1:0] a, input logic [MAXW-1:0] b,
                                     input int unsigned w);
        logic signed [MAXW-1:0] sum;
        logic signed [MAXW-1:0] hi;
        sum = $signed(sext(a, w)) + $signed(sext(b, w));
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (sum > hi) || (sum < ~hi);
    endfunction

endpackage

// File: rtl/pe_mac_pool_scratchpad.sv
// DEPTH x WIDTH register-file scratchpad: synchronous write, asynchronous read, no reset.
module pe_scratchpad
    import pe_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pe_mac_pool.sv
// Processing element: loads a job into scratchpads, then runs a saturating dot product with bias
// (CONV) or a max-pool reduction over cfg_len taps, and holds the result until it is accepted.
module pe_mac_pool
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH,
    parameter int RF_DEPTH   = 16,
    parameter int LEN_W      = $clog2(RF_DEPTH)+1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  cfg_mode,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic                  cfg_relu,
    input  logic [DATA_WIDTH-1:0] bias_in,
    input  logic                  actn_valid,
    output logic                  actn_ready,
    input  logic [DATA_WIDTH-1:0] actn_in,
    input  logic                  filt_valid,
    output logic                  filt_ready,
    input  logic [DATA_WIDTH-1:0] filt_in,
    output logic [ACC_WIDTH-1:0]  pe_out,
    output logic                  pe_out_valid,
    input  logic                  pe_out_ready,
    output logic                  busy,
    output logic [1:0]            pe_resp
);

    localparam int AW     = $clog2(RF_DEPTH);
    localparam int STAGES = 1;

    pe_state_e             state_q, state_d;
    pe_mode_e              mode_q, mode_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  relu_q, relu_d;
    logic [DATA_WIDTH-1:0] bias_q, bias_d;
    logic [LEN_W-1:0]      actn_cnt_q, actn_cnt_d, filt_cnt_q, filt_cnt_d, rd_idx_q, rd_idx_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d, prod_q, prod_d, out_q, out_d;
    logic [STAGES:0]       vld_pipe_q, vld_pipe_d, last_pipe_q, last_pipe_d;
    logic                  sat_q, sat_d, out_vld_q, out_vld_d, err_q, err_d;

    logic [DATA_WIDTH-1:0]         actn_rd, filt_rd;
    logic signed [2*DATA_WIDTH-1:0] mult;
    logic                          actn_fire, filt_fire, issue, len_ok;
    logic [LEN_W-1:0]              actn_cnt_nx, filt_cnt_nx;

    assign actn_ready  = (state_q == LOAD) && (actn_cnt_q < len_q);
    assign filt_ready  = (state_q == LOAD) && (mode_q == CONV) && (filt_cnt_q < len_q);
    assign actn_fire   = actn_valid && actn_ready;
    assign filt_fire   = filt_valid && filt_ready;
    assign actn_cnt_nx = actn_cnt_q + LEN_W'(actn_fire);
    assign filt_cnt_nx = filt_cnt_q + LEN_W'(filt_fire);
    assign issue       = (state_q == COMPUTE) && (rd_idx_q < len_q);
    assign len_ok      = (cfg_len != '0) && (cfg_len <= LEN_W'(RF_DEPTH));
    assign mult        = $signed(actn_rd) * $signed(filt_rd);

    pe_scratchpad #(.DEPTH(RF_DEPTH), .WIDTH(DATA_WIDTH)) u_actn_rf (
        .clk(clk), .we(actn_fire), .waddr(actn_cnt_q[AW-1:0]), .wdata(actn_in),
        .raddr(rd_idx_q[AW-1:0]), .rdata(actn_rd)
    );

    pe_scratchpad #(.DEPTH(RF_DEPTH), .WIDTH(DATA_WIDTH)) u_filt_rf (
        .clk(clk), .we(filt_fire), .waddr(filt_cnt_q[AW-1:0]), .wdata(filt_in),
        .raddr(rd_idx_q[AW-1:0]), .rdata(filt_rd)
    );

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        relu_d     = relu_q;
        bias_d     = bias_q;
        actn_cnt_d = actn_cnt_q;
        filt_cnt_d = filt_cnt_q;
        rd_idx_d   = rd_idx_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        sat_d      = sat_q;
        err_d      = 1'b0;

        // Stage 1 registers the tap product (or raw activation); stage 2 folds it into acc.
        vld_pipe_d  = {vld_pipe_q[STAGES-1:0], issue};
        last_pipe_d = {last_pipe_q[STAGES-1:0], issue && (rd_idx_q == len_q - LEN_W'(1))};
        if (issue) begin
            if (mode_q == CONV) prod_d = ACC_WIDTH'(sext(MAXW'(mult), 2*DATA_WIDTH));
            else                prod_d = ACC_WIDTH'(sext(MAXW'(actn_rd), DATA_WIDTH));
        end
        if (vld_pipe_q[0]) begin
            if (mode_q == CONV) begin
                acc_d = ACC_WIDTH'(sat_add(MAXW'(acc_q), MAXW'(prod_q), ACC_WIDTH));
                sat_d = sat_q | sat_hit(MAXW'(acc_q), MAXW'(prod_q), ACC_WIDTH);
            end else if ($signed(prod_q) > $signed(acc_q)) begin
                acc_d = prod_q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        mode_d     = pe_mode_e'(cfg_mode);
                        len_d      = cfg_len;
                        relu_d     = cfg_relu;
                        bias_d     = bias_in;
                        actn_cnt_d = '0;
                        filt_cnt_d = '0;
                        sat_d      = 1'b0;
                        state_d    = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                actn_cnt_d = actn_cnt_nx;
                filt_cnt_d = filt_cnt_nx;
                if (actn_cnt_nx == len_q && (mode_q == MAXPOOL || filt_cnt_nx == len_q)) begin
                    state_d  = COMPUTE;
                    rd_idx_d = '0;
                    if (mode_q == CONV) acc_d = ACC_WIDTH'(sext(MAXW'(bias_q), DATA_WIDTH));
                    else                acc_d = {1'b1, {(ACC_WIDTH-1){1'b0}}};
                end
            end
            COMPUTE: begin
                if (issue) rd_idx_d = rd_idx_q + LEN_W'(1);
                if (vld_pipe_q[STAGES] && last_pipe_q[STAGES]) begin
                    out_d     = (relu_q && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;
                    out_vld_d = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (pe_out_ready) begin
                    out_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= CONV;
            len_q       <= '0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            actn_cnt_q  <= '0;
            filt_cnt_q  <= '0;
            rd_idx_q    <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            out_q       <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            sat_q       <= 1'b0;
            out_vld_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            relu_q      <= relu_d;
            bias_q      <= bias_d;
            actn_cnt_q  <= actn_cnt_d;
            filt_cnt_q  <= filt_cnt_d;
            rd_idx_q    <= rd_idx_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            out_q       <= out_d;
            vld_pipe_q  <= vld_pipe_d;
            last_pipe_q <= last_pipe_d;
            sat_q       <= sat_d;
            out_vld_q   <= out_vld_d;
            err_q       <= err_d;
        end
    end

    assign pe_out       = out_q;
    assign pe_out_valid = out_vld_q;
    assign busy         = (state_q != IDLE);
    assign pe_resp      = {err_q, sat_q};

endmodule

// File: tb/tb_pe_mac_pool.sv
// Bench for pe_mac_pool: table of jobs scored through a result queue, plus hand-written
// sequences for backpressure, illegal lengths and reset during compute.
module tb_pe_mac_pool;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, cfg_mode = 1'b0, cfg_relu = 1'b0;
    logic [4:0]  cfg_len = '0;
    logic [7:0]  bias_in = '0, actn_in = '0, filt_in = '0;
    logic        actn_valid = 1'b0, filt_valid = 1'b0, pe_out_ready = 1'b1;
    logic        actn_ready, filt_ready, pe_out_valid, busy;
    logic [15:0] pe_out;
    logic [1:0]  pe_resp;

    pe_mac_pool dut (
        .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .cfg_relu(cfg_relu), .bias_in(bias_in), .actn_valid(actn_valid), .actn_ready(actn_ready),
        .actn_in(actn_in), .filt_valid(filt_valid), .filt_ready(filt_ready), .filt_in(filt_in),
        .pe_out(pe_out), .pe_out_valid(pe_out_valid), .pe_out_ready(pe_out_ready),
        .busy(busy), .pe_resp(pe_resp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0, n_chk = 0;

    typedef struct {
        logic            mode;
        int              len;
        logic            relu;
        logic            gappy;
        logic [7:0]      bias;
        logic [15:0][7:0] a;
        logic [15:0][7:0] w;
        logic [15:0]     exp_out;
        logic            exp_sat;
    } vec_t;

    vec_t       tbl[8];
    logic [16:0] sb_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    function automatic vec_t mk(input logic mode, input int len, input logic relu, input logic gappy,
                                input int bias, input int ex, input logic sat,
                                input int a0, input int a1, input int a2, input int a3,
                                input int w0, input int w1, input int w2, input int w3);
        vec_t v;
        v.mode = mode; v.len = len; v.relu = relu; v.gappy = gappy;
        v.bias = 8'(bias); v.exp_out = 16'(ex); v.exp_sat = sat;
        v.a = '0; v.w = '0;
        v.a[0] = 8'(a0); v.a[1] = 8'(a1); v.a[2] = 8'(a2); v.a[3] = 8'(a3);
        v.w[0] = 8'(w0); v.w[1] = 8'(w1); v.w[2] = 8'(w2); v.w[3] = 8'(w3);
        return v;
    endfunction

    // Issues start, then streams both operand sets; t_last is the edge of the final accepted beat.
    task automatic start_and_feed(input vec_t v, output int t_last);
        int   ai, fi, nf, guard;
        logic a_ok, f_ok, fseen;
        ai = 0; fi = 0; guard = 0; fseen = 1'b0;
        nf = v.mode ? 0 : v.len;
        start = 1'b1; cfg_mode = v.mode; cfg_len = 5'(v.len); cfg_relu = v.relu; bias_in = v.bias;
        @(posedge clk); #1;
        start = 1'b0;
        t_last = cyc;
        while ((ai < v.len || fi < nf) && guard < 200) begin
            actn_valid = (ai < v.len) && !(v.gappy && guard[0]);
            actn_in    = (ai < 16) ? v.a[ai[3:0]] : 8'h00;
            filt_valid = v.mode ? 1'b1 : (fi < nf);
            filt_in    = (fi < 16) ? v.w[fi[3:0]] : 8'h00;
            @(negedge clk);
            a_ok = actn_valid && actn_ready;
            f_ok = filt_valid && filt_ready;
            if (filt_ready) fseen = 1'b1;
            @(posedge clk); #1;
            if (a_ok) ai++;
            if (f_ok) fi++;
            if (a_ok || f_ok) t_last = cyc;
            guard++;
        end
        actn_valid = 1'b0;
        filt_valid = 1'b0;
        if (guard >= 200) begin
            n_chk++;
            $display("FAIL feed: beats not accepted within budget (actn %0d filt %0d)", ai, fi);
        end
        if (v.mode) chk("maxpool_filt_ready", 32'(fseen), 32'd0);
    endtask

    task automatic collect(input int t_last, input int len, input string name, input logic release_out);
        int          k;
        logic [16:0] e;
        k = 0;
        while (!pe_out_valid && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        if (!pe_out_valid) begin
            n_chk++;
            $display("FAIL %s: pe_out_valid never rose", name);
            return;
        end
        chk({name, "_lat"}, 32'(cyc - t_last), 32'(len + 2));
        if (sb_q.size() == 0) begin
            n_chk++;
            $display("FAIL %s: result with empty scoreboard", name);
        end else begin
            e = sb_q.pop_front();
            chk({name, "_out"}, 32'(pe_out), 32'(e[15:0]));
            chk({name, "_sat"}, 32'(pe_resp[0]), 32'(e[16]));
        end
        if (release_out) begin
            @(posedge clk); #1;
            chk({name, "_vld_drop"}, 32'(pe_out_valid), 32'd0);
            chk({name, "_idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        tbl[0] = mk(0, 3, 0, 0,   10,     42, 0,    1,    2, 3, 0,    4,  5, 6, 0);
        tbl[1] = mk(0, 2, 0, 1,    0,     -7, 0,   -2,    3, 0, 0,    5,  1, 0, 0);
        tbl[2] = mk(0, 2, 1, 1,    0,      0, 0,   -2,    3, 0, 0,    5,  1, 0, 0);
        tbl[3] = mk(1, 4, 0, 0,    0,      7, 0,   -5,    7, 3, 7,    0,  0, 0, 0);
        tbl[4] = mk(0, 2, 0, 0,    0,  32767, 1, -128, -128, 0, 0, -128, -128, 0, 0);
        tbl[5] = mk(0, 1, 0, 0, -128, -16384, 0, -128,    0, 0, 0,  127,  0, 0, 0);
        tbl[6] = mk(1, 1, 1, 0,    0,      0, 0, -128,    0, 0, 0,    0,  0, 0, 0);
        tbl[7] = mk(0, 16, 0, 0,  -1, -32768, 1,    0,    0, 0, 0,    0,  0, 0, 0);
        for (int j = 0; j < 16; j++) begin
            tbl[7].a[j] = 8'd127;
            tbl[7].w[j] = 8'h80;
        end

        actn_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(pe_out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_actn_ready", 32'(actn_ready), 32'd0);
        chk("rst_filt_ready", 32'(filt_ready), 32'd0);
        chk("rst_out", 32'(pe_out), 32'd0);
        chk("rst_resp", 32'(pe_resp), 32'd0);
        actn_valid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            sb_q.push_back({tbl[i].exp_sat, tbl[i].exp_out});
            start_and_feed(tbl[i], t);
            collect(t, tbl[i].len, $sformatf("vec%0d", i), 1'b1);
        end

        // Illegal lengths: one-cycle error pulse, never leaves IDLE.
        for (int i = 0; i < 2; i++) begin
            start = 1'b1;
            cfg_len = (i == 0) ? 5'd0 : 5'd17;
            @(posedge clk); #1;
            start = 1'b0;
            chk($sformatf("err%0d_pulse", i), 32'(pe_resp[1]), 32'd1);
            chk($sformatf("err%0d_busy", i), 32'(busy), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("err%0d_clear", i), 32'(pe_resp[1]), 32'd0);
            chk($sformatf("err%0d_idle", i), 32'(busy), 32'd0);
        end

        // Backpressure with start pulses while the result is held.
        pe_out_ready = 1'b0;
        sb_q.push_back({tbl[0].exp_sat, tbl[0].exp_out});
        start_and_feed(tbl[0], t);
        collect(t, tbl[0].len, "bp", 1'b0);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            cfg_len = (i % 2 == 1) ? 5'd3 : 5'd0;
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d_out", i), 32'(pe_out), 32'd42);
            chk($sformatf("bp_hold%0d_vld", i), 32'(pe_out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_err", i), 32'(pe_resp[1]), 32'd0);
        end
        start = 1'b0;
        cfg_len = 5'd0;
        @(posedge clk); #1;
        chk("bp_no_err", 32'(pe_resp[1]), 32'd0);
        chk("bp_still_vld", 32'(pe_out_valid), 32'd1);
        pe_out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_vld_drop", 32'(pe_out_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset in the middle of a saturating job, then a clean job.
        start_and_feed(tbl[7], t);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_pre", 32'(busy), 32'd1);
        chk("mid_sat_pre", 32'(pe_resp[0]), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(pe_out_valid), 32'd0);
        chk("mid_rst_out", 32'(pe_out), 32'd0);
        chk("mid_rst_resp", 32'(pe_resp), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_quiet", 32'(pe_out_valid), 32'd0);
        sb_q.push_back({tbl[0].exp_sat, tbl[0].exp_out});
        start_and_feed(tbl[0], t);
        collect(t, tbl[0].len, "post_rst", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
